// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode encodings, fill default and width helper.
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int unsigned SPI_FILL_DEFAULT = 0;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous TX word FIFO; full pushes and empty pops are ignored.
module spi_tx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic [DATA_W-1:0]                 i_data,
    output logic [DATA_W-1:0]                 o_data,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    o_count
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [CW-1:0]     r_count;
    logic              w_push, w_pop;

    assign o_full  = r_count == CW'(FIFO_DEPTH);
    assign o_empty = r_count == '0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampled SPI slave, any CPOL/CPHA, with a TX FIFO feeding MISO.
// Pins are synchronised into clk; SCLK must run at most 1/(2*(SYNC_STAGES+2)) of clk.
module spi_slave_fifo
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                FIFO_DEPTH  = 4,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL        = DATA_W'(SPI_FILL_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           spi_cs_n,
    input  logic                           spi_sclk,
    input  logic                           spi_mosi,
    output logic                           spi_miso,
    output logic                           spi_miso_oe,
    input  logic [DATA_W-1:0]              tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic [clog2(FIFO_DEPTH+1)-1:0] tx_count,
    output logic [DATA_W-1:0]              rx_data,
    output logic                           rx_valid,
    output logic                           underrun,
    output logic                           wake
);

    localparam int CNT_W = clog2(DATA_W);

    logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_sclk_d, r_cs_d, r_oe, r_done, r_underrun, r_rx_valid, r_wake;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_tx_sh, r_rx_sh, r_rx_data, w_fifo_data;
    logic                   w_cs, w_sclk, w_mosi, w_edge, w_lead, w_trail;
    logic                   w_sample, w_drive, w_start, w_last, w_load, w_full, w_empty;

    assign w_cs     = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_edge   = w_sclk ^ r_sclk_d;
    assign w_lead   = w_edge & (w_sclk != CPOL);
    assign w_trail  = w_edge & (w_sclk == CPOL);
    assign w_sample = r_oe & ~w_cs & (CPHA ? w_trail : w_lead);
    assign w_drive  = r_oe & ~w_cs & (CPHA ? w_lead : w_trail);
    assign w_start  = r_cs_d & ~w_cs;
    assign w_last   = w_sample & (r_cnt == CNT_W'(DATA_W - 1));
    assign w_load   = w_start | w_last;

    assign spi_miso    = r_oe & r_tx_sh[DATA_W-1];
    assign spi_miso_oe = r_oe;
    assign tx_ready    = ~w_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign underrun    = r_underrun;
    assign wake        = r_wake;

    always_ff @(posedge clk) begin
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        r_sclk_d    <= w_sclk;
    end

    // r_cs_d resets low so a select held across reset needs a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_d     <= 1'b0;
            r_oe       <= 1'b0;
            r_cnt      <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_wake     <= 1'b0;
        end else begin
            r_cs_d     <= w_cs;
            r_done     <= w_last;
            r_rx_valid <= r_done;
            r_underrun <= w_load & w_empty;
            r_wake     <= tx_count != '0;
            if (r_done) r_rx_data <= r_rx_sh;
            if (w_cs) begin
                r_oe    <= 1'b0;
                r_cnt   <= '0;
                r_rx_sh <= '0;
            end else begin
                if (w_start) r_oe <= 1'b1;
                if (w_sample) begin
                    r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_mosi};
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                end
                if (w_load) r_tx_sh <= w_empty ? FILL : w_fifo_data;
                else if (w_drive && r_cnt != '0) r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
            end
        end
    end

    spi_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (tx_valid),
        .i_pop   (w_load),
        .i_data  (tx_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (tx_count)
    );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed checks of four mode instances (mode 0 carries FILL=0xFF).
module tb_spi_slave_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = '0;
    logic       cs_n [4] = '{default: 1'b1};
    logic       sclk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       txv [4] = '{default: 1'b0};
    logic       miso [4], oe [4], txr [4], rxv [4], unr [4], wake [4];
    logic [2:0] txc [4];
    logic [7:0] rxd [4];
    logic [7:0] rxw [4][8];
    int         rxn [4] = '{default: 0};
    int         unn [4] = '{default: 0};
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_fifo #(
            .DATA_W      (8),
            .FIFO_DEPTH  (4),
            .CPOL        ((g / 2) % 2 == 1),
            .CPHA        (g % 2 == 1),
            .SYNC_STAGES (2),
            .FILL        (g == 0 ? 8'hFF : 8'h00)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .spi_cs_n    (cs_n[g]),
            .spi_sclk    (sclk[g]),
            .spi_mosi    (mosi),
            .spi_miso    (miso[g]),
            .spi_miso_oe (oe[g]),
            .tx_data     (tx_data),
            .tx_valid    (txv[g]),
            .tx_ready    (txr[g]),
            .tx_count    (txc[g]),
            .rx_data     (rxd[g]),
            .rx_valid    (rxv[g]),
            .underrun    (unr[g]),
            .wake        (wake[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rxv[k]) begin
                rxw[k][rxn[k] & 7] = rxd[k];
                rxn[k]++;
            end
            if (unr[k]) unn[k]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic push(input int m, input logic [7:0] d);
        txv[m] = 1'b1;
        tx_data = d;
        @(negedge clk);
        txv[m] = 1'b0;
    endtask

    task automatic xfer(input int m, input logic [7:0] mo, input int nb, output logic [7:0] mi);
        bit cpol = (m / 2) % 2 == 1;
        bit cpha = m % 2 == 1;
        mi = '0;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!cpha) mosi = mo[i];
            half();
            sclk[m] = ~cpol;
            if (cpha) mosi = mo[i];
            else mi[i] = miso[m];
            half();
            sclk[m] = cpol;
            if (cpha) mi[i] = miso[m];
        end
    endtask

    initial begin
        logic [7:0] r;
        int n0, u0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_miso", miso[0], 0);
        check("rst_oe", oe[0], 0);
        check("rst_ready", txr[0], 1);
        check("rst_count", txc[0], 0);
        check("rst_rxd", rxd[0], 0);
        check("rst_rxv", rxv[0], 0);
        check("rst_wake", wake[0], 0);
        check("rst_unr", unr[0], 0);

        push(0, 8'hA5);
        push(0, 8'h3C);
        check("t1_count2", txc[0], 2);
        @(negedge clk);
        check("t1_wake1", wake[0], 1);
        n0 = rxn[0];
        cs_n[0] = 1'b0;
        half();
        xfer(0, 8'h5A, 8, r);
        check("t1_miso_a5", r, 8'hA5);
        xfer(0, 8'hC3, 8, r);
        check("t1_miso_3c", r, 8'h3C);
        half();
        cs_n[0] = 1'b1;
        half();
        check("t1_rx_n", rxn[0] - n0, 2);
        check("t1_rx0", rxw[0][n0 & 7], 8'h5A);
        check("t1_rx1", rxw[0][(n0 + 1) & 7], 8'hC3);
        check("t1_count0", txc[0], 0);
        check("t1_wake0", wake[0], 0);

        for (int m = 1; m < 4; m++) begin
            push(m, 8'h81);
            cs_n[m] = 1'b0;
            half();
            xfer(m, 8'h7E, 8, r);
            half();
            cs_n[m] = 1'b1;
            half();
            check($sformatf("t2_m%0d_miso", m), r, 8'h81);
            check($sformatf("t2_m%0d_rx", m), rxd[m], 8'h7E);
            check($sformatf("t2_m%0d_rxn", m), rxn[m], 1);
        end

        u0 = unn[0];
        n0 = rxn[0];
        cs_n[0] = 1'b0;
        half();
        check("t3_underrun", unn[0] - u0, 1);
        xfer(0, 8'h96, 8, r);
        half();
        cs_n[0] = 1'b1;
        half();
        check("t3_miso_fill", r, 8'hFF);
        check("t3_rx", rxd[0], 8'h96);
        check("t3_rxn", rxn[0] - n0, 1);

        txv[0] = 1'b1;
        for (int d = 1; d <= 5; d++) begin
            tx_data = 8'(d);
            @(negedge clk);
        end
        txv[0] = 1'b0;
        check("t4_count", txc[0], 4);
        check("t4_ready", txr[0], 0);
        cs_n[0] = 1'b0;
        half();
        for (int k = 1; k <= 5; k++) begin
            xfer(0, 8'h00, 8, r);
            check($sformatf("t4_word%0d", k), r, k < 5 ? 8'(k) : 8'hFF);
        end
        half();
        cs_n[0] = 1'b1;
        half();
        check("t4_ready_back", txr[0], 1);

        push(0, 8'h12);
        push(0, 8'h34);
        n0 = rxn[0];
        cs_n[0] = 1'b0;
        half();
        xfer(0, 8'h12, 3, r);
        half();
        cs_n[0] = 1'b1;
        half();
        check("t5_no_rxv", rxn[0] - n0, 0);
        check("t5_miso", miso[0], 0);
        check("t5_oe", oe[0], 0);
        cs_n[0] = 1'b0;
        half();
        check("t5_oe_sel", oe[0], 1);
        xfer(0, 8'hA7, 8, r);
        half();
        cs_n[0] = 1'b1;
        half();
        check("t5_next_word", r, 8'h34);
        check("t5_rx", rxd[0], 8'hA7);

        push(0, 8'h55);
        push(0, 8'h66);
        cs_n[0] = 1'b0;
        half();
        xfer(0, 8'h00, 3, r);
        reset = 1'b1;
        @(negedge clk);
        check("t6_count", txc[0], 0);
        check("t6_ready", txr[0], 1);
        check("t6_wake", wake[0], 0);
        check("t6_oe", oe[0], 0);
        reset = 1'b0;
        cs_n[0] = 1'b1;
        half();
        cs_n[0] = 1'b0;
        half();
        xfer(0, 8'h3C, 8, r);
        half();
        cs_n[0] = 1'b1;
        half();
        check("t6_fill", r, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
